// File: rtl/uart_ns_rx_pkg.sv
// uart_ns_rx_pkg -- shared UART definitions used by the uart_ns_rx slice.
// Holds the receive FSM state type, data/divider widths and bit-count constants.
package uart_ns_rx_pkg;

    localparam int unsigned UART_DATA_SIZE       = 8;
    localparam int unsigned UART_BAUD_DIV_SIZE   = 16;
    localparam int unsigned UART_RX_DATA_BITS    = 8;
    localparam int unsigned UART_RX_BIT_CNT_SIZE = 3;

    // Counter constant used for the "sample now" compare and the decrement.
    localparam logic [UART_BAUD_DIV_SIZE-1:0] UART_BAUD_ONE = UART_BAUD_DIV_SIZE'(1);

    // Index of the last data bit within a frame.
    localparam logic [UART_RX_BIT_CNT_SIZE-1:0] UART_RX_LAST_BIT =
        UART_RX_BIT_CNT_SIZE'(UART_RX_DATA_BITS - 1);

    // Encodings match the legacy 2-bit state register.
    typedef enum logic [1:0] {
        UART_RX_IDLE  = 2'd0,
        UART_RX_START = 2'd1,
        UART_RX_DATA  = 2'd2,
        UART_RX_STOP  = 2'd3
    } type_uart_rx_states_e;

    // True when the stop sample being taken is the final one of the frame.
    function automatic logic uart_rx_last_stop(input logic two_stop, input logic stop_cnt);
        return !two_stop || stop_cnt;
    endfunction

endpackage

// File: rtl/uart_ns_rx_sync.sv
// uart_ns_rx_sync -- SYNC_STAGES-deep synchronizer for the asynchronous rx line.
// Flops reset to 1 so the idle-high line does not look like a start edge.
module uart_ns_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw line into the chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    end

    // Synchronizer flops, preset to line-idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_ns_rx.sv
// uart_ns_rx -- 8N1/8N2 UART receiver with a single-entry holding register.
// Optional macro UART_NS_RX_FRAME_ERR_EN: check stop bits, pulse frame_err_o
// and drop bytes whose stop sample is low. Undefined: stop bits are ignored.
module uart_ns_rx
    import uart_ns_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_pin_i,
    input  logic [UART_BAUD_DIV_SIZE-1:0] baud_div_i,
    input  logic                          two_stop_bits,
    output logic [UART_DATA_SIZE-1:0]     rx_data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          overrun_o,
    output logic                          frame_err_o
);

    logic rx_sync;

    uart_ns_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx_pin_i),
        .q_o   (rx_sync)
    );

    type_uart_rx_states_e              state_q,    state_d;
    logic [UART_BAUD_DIV_SIZE-1:0]     cnt_q,      cnt_d;
    logic [UART_RX_BIT_CNT_SIZE-1:0]   bit_cnt_q,  bit_cnt_d;
    logic                              stop_cnt_q, stop_cnt_d;
    logic [UART_DATA_SIZE-1:0]         shift_q,    shift_d;
    logic [UART_DATA_SIZE-1:0]         hold_q,     hold_d;
    logic                              valid_q,    valid_d;
    logic                              overrun_q,  overrun_d;
    logic                              rx_prev_q,  rx_prev_d;
`ifdef UART_NS_RX_FRAME_ERR_EN
    logic                              stop_err_q, stop_err_d;
    logic                              frame_err_q, frame_err_d;
`endif

    logic fall;
    logic tick;
    logic byte_done;
    logic byte_bad;

    // Falling edge of the synchronized line; a line held low produces no edge.
    assign fall = rx_prev_q && !rx_sync;
    assign tick = (cnt_q == UART_BAUD_ONE);

    // Frame FSM, bit sampling and holding-register update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        valid_d    = valid_q;
        overrun_d  = 1'b0;
        rx_prev_d  = rx_sync;
        byte_done  = 1'b0;
        byte_bad   = 1'b0;
`ifdef UART_NS_RX_FRAME_ERR_EN
        stop_err_d  = stop_err_q;
        frame_err_d = 1'b0;
`endif

        case (state_q)
            UART_RX_IDLE: begin
                if (fall) begin
                    state_d    = UART_RX_START;
                    cnt_d      = baud_div_i >> 1;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
`ifdef UART_NS_RX_FRAME_ERR_EN
                    stop_err_d = 1'b0;
`endif
                end
            end
            UART_RX_START: begin
                if (tick) begin
                    cnt_d   = baud_div_i;
                    state_d = rx_sync ? UART_RX_IDLE : UART_RX_DATA;
                end else begin
                    cnt_d = cnt_q - UART_BAUD_ONE;
                end
            end
            UART_RX_DATA: begin
                if (tick) begin
                    shift_d   = {rx_sync, shift_q[UART_DATA_SIZE-1:1]};
                    cnt_d     = baud_div_i;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == UART_RX_LAST_BIT) begin
                        state_d = UART_RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - UART_BAUD_ONE;
                end
            end
            UART_RX_STOP: begin
                if (tick) begin
                    cnt_d      = baud_div_i;
                    stop_cnt_d = 1'b1;
                    if (uart_rx_last_stop(two_stop_bits, stop_cnt_q)) begin
                        state_d   = UART_RX_IDLE;
                        byte_done = 1'b1;
`ifdef UART_NS_RX_FRAME_ERR_EN
                        byte_bad  = stop_err_q || !rx_sync;
`endif
                    end
`ifdef UART_NS_RX_FRAME_ERR_EN
                    else begin
                        stop_err_d = stop_err_q || !rx_sync;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - UART_BAUD_ONE;
                end
            end
            default: begin
                state_d = UART_RX_IDLE;
            end
        endcase

        // A completed byte wins over a same-cycle read; drop it only if the
        // unread byte is not being consumed this cycle.
        if (byte_done && !byte_bad) begin
            if (valid_q && !ready_i) begin
                overrun_d = 1'b1;
            end else begin
                hold_d  = shift_q;
                valid_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

`ifdef UART_NS_RX_FRAME_ERR_EN
        frame_err_d = byte_done && byte_bad;
`endif
    end

    // State registers; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= UART_RX_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            hold_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            rx_prev_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            rx_prev_q  <= rx_prev_d;
        end
    end

`ifdef UART_NS_RX_FRAME_ERR_EN
    // Stop-bit error accumulator and frame error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            stop_err_q  <= stop_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err_o = frame_err_q;
`else
    assign frame_err_o = 1'b0;
`endif

    assign rx_data_o = hold_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_uart_ns_rx.sv
// tb_uart_ns_rx -- scoreboard bench for uart_ns_rx.
// Inputs change on the falling clock edge; outputs are sampled 1 ns after it.
module tb_uart_ns_rx;
    import uart_ns_rx_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          rx_pin_i = 1'b1;
    logic [UART_BAUD_DIV_SIZE-1:0] baud_div_i = 16'd16;
    logic                          two_stop_bits = 1'b0;
    logic [UART_DATA_SIZE-1:0]     rx_data_o;
    logic                          valid_o;
    logic                          ready_i = 1'b0;
    logic                          overrun_o;
    logic                          frame_err_o;

    uart_ns_rx #(
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_pin_i      (rx_pin_i),
        .baud_div_i    (baud_div_i),
        .two_stop_bits (two_stop_bits),
        .rx_data_o     (rx_data_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .overrun_o     (overrun_o),
        .frame_err_o   (frame_err_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned fall_cyc = 0;
    int unsigned last_valid_cyc = 0;
    int unsigned valid_rises = 0;
    int unsigned valid_cycles = 0;
    int unsigned ovr_cnt = 0;
    int unsigned ferr_cnt = 0;
    logic        valid_prev = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_b;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: handshakes pop the scoreboard; pulses and valid edges are counted.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (valid_o && !valid_prev) begin
                valid_rises++;
                last_valid_cyc = cyc;
            end
            if (valid_o)     valid_cycles++;
            if (overrun_o)   ovr_cnt++;
            if (frame_err_o) ferr_cnt++;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_byte", exp_q.size(), 1);
                end else begin
                    exp_b = exp_q.pop_front();
                    check_eq("rx_data", {24'd0, rx_data_o}, {24'd0, exp_b});
                end
            end
        end
        valid_prev = valid_o;
    end

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_low);
        int unsigned b;
        b = baud_div_i;
        @(negedge clk);
        rx_pin_i = 1'b0;
        fall_cyc = cyc;
        repeat (b) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_pin_i = d[i];
            repeat (b) @(negedge clk);
        end
        rx_pin_i = !stop_low;
        repeat (b) @(negedge clk);
        if (two_stop_bits) repeat (b) @(negedge clk);
        rx_pin_i = 1'b1;
    endtask

    // Start-edge to valid_o latency window, centred on the nominal frame time.
    task automatic check_latency(input string tag, input int unsigned b, input int unsigned nstop);
        int unsigned nominal;
        int unsigned lat;
        nominal = 2 + 1 + b / 2 + b * (8 + nstop);
        lat = last_valid_cyc - fall_cyc;
        check_eq(tag, {31'd0, (lat + 2 >= nominal) && (lat <= nominal + 2)}, 32'd1);
    endtask

    int unsigned r0, v0, o0, f0;
    logic [7:0] part;

    initial begin
        ready_i = 1'b1;
        idle(3);
        #1;
        check_eq("reset_valid", {31'd0, valid_o}, 32'd0);
        check_eq("reset_data", {24'd0, rx_data_o}, 32'd0);
        check_eq("reset_overrun", {31'd0, overrun_o}, 32'd0);
        check_eq("reset_frame_err", {31'd0, frame_err_o}, 32'd0);
        rst_n = 1'b1;
        idle(5);

        // 0xA5 at divider 16, one stop bit.
        r0 = valid_rises; v0 = valid_cycles; o0 = ovr_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0);
        idle(30);
        check_eq("a5_valid_rises", valid_rises - r0, 1);
        check_eq("a5_valid_one_cycle", valid_cycles - v0, 1);
        check_eq("a5_no_overrun", ovr_cnt - o0, 0);
        check_latency("a5_latency", 16, 1);

        // 0x3C at divider 8, two stop bits.
        baud_div_i = 16'd8;
        two_stop_bits = 1'b1;
        r0 = valid_rises;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0);
        idle(30);
        check_eq("3c_valid_rises", valid_rises - r0, 1);
        check_latency("3c_latency_two_stop", 8, 2);

        // 3-cycle glitch is rejected, then a normal byte is still received.
        baud_div_i = 16'd16;
        two_stop_bits = 1'b0;
        r0 = valid_rises; o0 = ovr_cnt; f0 = ferr_cnt;
        @(negedge clk);
        rx_pin_i = 1'b0;
        idle(3);
        rx_pin_i = 1'b1;
        idle(60);
        check_eq("glitch_no_valid", valid_rises - r0, 0);
        check_eq("glitch_no_overrun", ovr_cnt - o0, 0);
        check_eq("glitch_no_frame_err", ferr_cnt - f0, 0);
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b0);
        idle(30);
        check_eq("post_glitch_rises", valid_rises - r0, 1);

        // Back-to-back 0x11, 0x22 with no reader: second byte overruns.
        ready_i = 1'b0;
        o0 = ovr_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        idle(30);
        check_eq("overrun_once", ovr_cnt - o0, 1);
        check_eq("overrun_valid_held", {31'd0, valid_o}, 32'd1);
        check_eq("overrun_data_kept", {24'd0, rx_data_o}, 32'h11);
        @(negedge clk);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        #1;
        check_eq("ready_clears_valid", {31'd0, valid_o}, 32'd0);
        check_eq("overrun_sb_empty", exp_q.size(), 0);

        // 0x55 with a low stop bit.
        ready_i = 1'b1;
        r0 = valid_rises; f0 = ferr_cnt;
`ifdef UART_NS_RX_FRAME_ERR_EN
        send_frame(8'h55, 1'b1);
        idle(30);
        check_eq("ferr_pulse", ferr_cnt - f0, 1);
        check_eq("ferr_no_valid", valid_rises - r0, 0);
`else
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        idle(30);
        check_eq("ferr_tied_low", ferr_cnt - f0, 0);
        check_eq("ferr_byte_delivered", valid_rises - r0, 1);
`endif

        // Reset during data bit 4 with an unread byte held.
        ready_i = 1'b0;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0);
        idle(30);
        check_eq("pre_reset_valid", {31'd0, valid_o}, 32'd1);
        part = 8'h81;
        @(negedge clk);
        rx_pin_i = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_pin_i = part[i];
            repeat (16) @(negedge clk);
        end
        rx_pin_i = part[4];
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midreset_valid", {31'd0, valid_o}, 32'd0);
        check_eq("midreset_data", {24'd0, rx_data_o}, 32'd0);
        check_eq("midreset_overrun", {31'd0, overrun_o}, 32'd0);
        check_eq("midreset_frame_err", {31'd0, frame_err_o}, 32'd0);
        exp_q.delete();
        idle(4);
        rx_pin_i = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(10);
        ready_i = 1'b1;
        r0 = valid_rises;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b0);
        idle(30);
        check_eq("post_reset_rises", valid_rises - r0, 1);

        check_eq("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
